// File: rtl/sudoku_checker.sv
// Sudoku guess-grid store with a row/column/box rule scanner: one cell per cycle, 3*N*N cycles per check.
// Grid edits and check requests are honoured only while idle (busy=0). Build option: SUDOKU_CHK_EARLY_EXIT_EN.
module sudoku_checker #(
   parameter  int BOX = 2,
   localparam int N   = BOX * BOX,
   localparam int VW  = $clog2(N + 1),
   localparam int AW  = $clog2(N * N),
   localparam int GW  = $clog2(3 * N)
) (
   input  logic          clka,
   input  logic          restart_n,
   input  logic          cell_we,
   input  logic [AW-1:0] cell_addr,
   input  logic [VW-1:0] cell_val,
   input  logic          clr,
   input  logic          dp_check,
   output logic          busy,
   output logic          done,
   output logic          solved,
   output logic [GW-1:0] fail_grp
);
   localparam int NN = N * N;
   localparam int EW = $clog2(N);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t        state_q, state_d;
   logic [GW-1:0] g_q, g_d;
   logic [EW-1:0] e_q, e_d;
   logic [N-1:0]  seen_q, seen_d;
   logic          fail_q, fail_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          solved_q, solved_d;
   logic [GW-1:0] fail_grp_q, fail_grp_d;
   logic [VW-1:0] grid_q [NN];

   int            row_i, col_i, box_i;
   logic [AW-1:0] rd_addr;
   logic [VW-1:0] rd_val;
   logic [N-1:0]  mask_cur, bit_m;
   logic          in_range, cell_fail, last, addr_ok;

   assign addr_ok = int'(cell_addr) < NN;

   // Map the scan position (group, element) onto a row-major cell address.
   always_comb begin
      row_i = 0;
      col_i = 0;
      box_i = 0;
      if (int'(g_q) < N) begin
         row_i = int'(g_q);
         col_i = int'(e_q);
      end else if (int'(g_q) < 2 * N) begin
         row_i = int'(e_q);
         col_i = int'(g_q) - N;
      end else begin
         box_i = int'(g_q) - 2 * N;
         row_i = (box_i / BOX) * BOX + int'(e_q) / BOX;
         col_i = (box_i % BOX) * BOX + int'(e_q) % BOX;
      end
      rd_addr = AW'(row_i * N + col_i);
   end

   assign rd_val    = grid_q[rd_addr];
   assign mask_cur  = (e_q == '0) ? '0 : seen_q;
   assign in_range  = (rd_val != '0) && (int'(rd_val) <= N);
   assign bit_m     = in_range ? ({{(N-1){1'b0}}, 1'b1} << (rd_val - VW'(1))) : '0;
   assign cell_fail = !in_range || (|(mask_cur & bit_m));
   assign last      = (g_q == GW'(3 * N - 1)) && (e_q == EW'(N - 1));

   always_comb begin
      state_d    = state_q;
      g_d        = g_q;
      e_d        = e_q;
      seen_d     = seen_q;
      fail_d     = fail_q;
      solved_d   = solved_q;
      fail_grp_d = fail_grp_q;
      case (state_q)
         IDLE: begin
            if (clr || (cell_we && addr_ok)) solved_d = 1'b0;
            if (dp_check) begin
               state_d    = SCAN;
               g_d        = '0;
               e_d        = '0;
               fail_d     = 1'b0;
               solved_d   = 1'b0;
               fail_grp_d = '0;
            end
         end
         SCAN: begin
            seen_d = mask_cur | bit_m;
            fail_d = fail_q | cell_fail;
            if (cell_fail && !fail_q) fail_grp_d = g_q;
            if (e_q == EW'(N - 1)) begin
               e_d = '0;
               g_d = g_q + GW'(1);
            end else begin
               e_d = e_q + EW'(1);
            end
`ifdef SUDOKU_CHK_EARLY_EXIT_EN
            if (last || cell_fail) begin
`else
            if (last) begin
`endif
               state_d  = DONE;
               solved_d = !(fail_q || cell_fail);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clka or negedge restart_n) begin
      if (!restart_n) begin
         state_q    <= IDLE;
         g_q        <= '0;
         e_q        <= '0;
         seen_q     <= '0;
         fail_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         solved_q   <= 1'b0;
         fail_grp_q <= '0;
      end else begin
         state_q    <= state_d;
         g_q        <= g_d;
         e_q        <= e_d;
         seen_q     <= seen_d;
         fail_q     <= fail_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         solved_q   <= solved_d;
         fail_grp_q <= fail_grp_d;
      end
   end

   // Clear wins over a write; both only while idle.
   always_ff @(posedge clka or negedge restart_n) begin
      if (!restart_n) begin
         for (int i = 0; i < NN; i++) grid_q[i] <= '0;
      end else if (state_q == IDLE) begin
         if (clr) begin
            for (int i = 0; i < NN; i++) grid_q[i] <= '0;
         end else if (cell_we && addr_ok) begin
            grid_q[cell_addr] <= cell_val;
         end
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign solved   = solved_q;
   assign fail_grp = fail_grp_q;

endmodule

// File: tb/tb_sudoku_checker.sv
// Directed bench for sudoku_checker at BOX=2 (4x4 grid); expectations adapt to SUDOKU_CHK_EARLY_EXIT_EN.
module tb_sudoku_checker;
   localparam int FULL = 48;
`ifdef SUDOKU_CHK_EARLY_EXIT_EN
   localparam bit EE = 1'b1;
`else
   localparam bit EE = 1'b0;
`endif

   logic       clka = 1'b0;
   logic       restart_n = 1'b0;
   logic       cell_we = 1'b0;
   logic [3:0] cell_addr = '0;
   logic [2:0] cell_val = '0;
   logic       clr = 1'b0;
   logic       dp_check = 1'b0;
   logic       busy, done, solved;
   logic [3:0] fail_grp;

   int n_chk = 0;
   int n_fail = 0;

   sudoku_checker #(.BOX(2)) dut (
      .clka      (clka),
      .restart_n (restart_n),
      .cell_we   (cell_we),
      .cell_addr (cell_addr),
      .cell_val  (cell_val),
      .clr       (clr),
      .dp_check  (dp_check),
      .busy      (busy),
      .done      (done),
      .solved    (solved),
      .fail_grp  (fail_grp)
   );

   always #5 clka = ~clka;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Done latency for a first failure at scan index i.
   function automatic int lat_of(input int i);
      return EE ? i + 1 : FULL;
   endfunction

   task automatic write_cell(input logic [3:0] a, input logic [2:0] v);
      cell_we = 1'b1; cell_addr = a; cell_val = v;
      @(posedge clka); #1;
      cell_we = 1'b0;
   endtask

   task automatic load_rows(input logic [15:0] r0, input logic [15:0] r1,
                            input logic [15:0] r2, input logic [15:0] r3);
      logic [15:0] rows [4];
      rows[0] = r0; rows[1] = r1; rows[2] = r2; rows[3] = r3;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            write_cell(4'(r * 4 + c), 3'(rows[r][15 - 4 * c -: 4]));
   endtask

   task automatic do_check(input string tag, input int exp_lat, input int exp_solved,
                           input int exp_grp, input int inject_at, input bit with_clr);
      int lat, busy_cnt, done_cnt;
      lat = -1; busy_cnt = 0; done_cnt = 0;
      dp_check = 1'b1; clr = with_clr;
      @(posedge clka); #1;
      dp_check = 1'b0; clr = 1'b0;
      for (int j = 0; j < 300; j++) begin
         cell_we = 1'b0; dp_check = 1'b0;
         if (j == inject_at) begin
            cell_we = 1'b1; cell_addr = 4'd0; cell_val = 3'd4; dp_check = 1'b1;
         end
         if (busy) busy_cnt++;
         if (done) begin
            done_cnt++;
            if (lat < 0) lat = j;
         end
         if (!busy) break;
         @(posedge clka); #1;
      end
      cell_we = 1'b0; dp_check = 1'b0;
      chk({tag, "_latency"}, lat, exp_lat);
      chk({tag, "_busy_cycles"}, busy_cnt, exp_lat + 1);
      chk({tag, "_done_pulses"}, done_cnt, 1);
      chk({tag, "_solved"}, solved, exp_solved);
      if (exp_solved == 0) chk({tag, "_fail_grp"}, fail_grp, exp_grp);
   endtask

   initial begin
      int dcnt;
      #12;
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_solved", solved, 0);
      chk("reset_fail_grp", fail_grp, 0);
      restart_n = 1'b1;
      @(posedge clka); #1;

      load_rows(16'h1234, 16'h3412, 16'h2143, 16'h4321);
      do_check("valid", FULL, 1, 0, -1, 1'b0);
      write_cell(4'd0, 3'd1);
      chk("edit_drops_solved", solved, 0);

      write_cell(4'd0, 3'd2);
      do_check("row_dup", lat_of(1), 0, 0, -1, 1'b0);

      load_rows(16'h1234, 16'h1234, 16'h2143, 16'h4321);
      do_check("col_dup", lat_of(17), 0, 4, -1, 1'b0);

      clr = 1'b1;
      @(posedge clka); #1;
      clr = 1'b0;
      do_check("empty", lat_of(0), 0, 0, -1, 1'b0);

      load_rows(16'h1234, 16'h3412, 16'h2143, 16'h4321);
      write_cell(4'd5, 3'd5);
      do_check("over_n", lat_of(5), 0, 1, -1, 1'b0);

      write_cell(4'd5, 3'd4);
      do_check("ignored_req", FULL, 1, 0, 10, 1'b0);
      chk("ignored_req_hold", solved, 1);
      do_check("readback", FULL, 1, 0, -1, 1'b0);

      do_check("clr_and_check", lat_of(0), 0, 0, -1, 1'b1);

      load_rows(16'h1234, 16'h3412, 16'h2143, 16'h4321);
      dp_check = 1'b1;
      @(posedge clka); #1;
      dp_check = 1'b0;
      repeat (20) @(posedge clka);
      #1;
      restart_n = 1'b0;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_solved", solved, 0);
      @(posedge clka); #1;
      restart_n = 1'b1;
      dcnt = 0;
      for (int j = 0; j < 80; j++) begin
         @(posedge clka); #1;
         if (done) dcnt++;
      end
      chk("abort_no_done", dcnt, 0);
      do_check("after_abort", lat_of(0), 0, 0, -1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
